// File: rtl/secuenciador_corrimiento.sv
// rtl/secuenciador_corrimiento.sv - multi-pass shift sequencer driving an external combinational shift unit
//
// A shift of in_cnt positions is split into passes of at most MAXD positions.
// Each pass feeds acc/op/step to the external shift unit and registers its result.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_ready is high only when idle
//   in_f, in_h, in_cnt    operand, op code (shift unit encoding), total shift count
//   out_valid/out_ready   result handshake
//   out_s                 final result, held stable while out_valid is high
//   busy                  high while a job is running or waiting for handoff
//   sh_f, sh_h, sh_d      operand, op and per-pass amount presented to the shift unit
//   sh_s                  shift unit result
//
// Configuration macro
//   ROT_MOD_EN  when defined, rotate counts are reduced modulo N at accept
//               (N must be a power of two); results are unchanged, only latency.

module secuenciador_corrimiento #(
    parameter  int N  = 4,
    parameter  int CW = 4,
    localparam int DW = (N - 1) / 2 + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_f,
    input  logic [2:0]    in_h,
    input  logic [CW-1:0] in_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_s,
    output logic          busy,
    output logic [N-1:0]  sh_f,
    output logic [2:0]    sh_h,
    output logic [DW-1:0] sh_d,
    input  logic [N-1:0]  sh_s
);

    localparam int            MAXD    = (2 ** DW) - 1;
    localparam logic [CW-1:0] MAXD_CW = CW'(MAXD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_XFER = 3'b000;
    localparam logic [2:0] OP_ZERO = 3'b011;
`ifdef ROT_MOD_EN
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
`endif

    logic [1:0]    state;
    logic [N-1:0]  acc;
    logic [2:0]    op;
    logic [CW-1:0] rem;
    logic [CW-1:0] cnt_lat;
    logic [DW-1:0] step;
    logic [CW-1:0] rem_next;

    // Count latched at accept. Transfer and zero need no shifting, so they
    // start with nothing remaining and make a single pass with amount 0.
    always_comb begin
        cnt_lat = in_cnt;
        if (in_h == OP_XFER || in_h == OP_ZERO) begin
            cnt_lat = '0;
        end
`ifdef ROT_MOD_EN
        else if (in_h == OP_ROL || in_h == OP_ROR) begin
            cnt_lat = in_cnt & CW'(N - 1);
        end
`endif
    end

    // Largest legal step this pass; never exceeds rem, so rem cannot underflow.
    always_comb begin
        step     = (rem > MAXD_CW) ? DW'(MAXD) : rem[DW-1:0];
        rem_next = rem - CW'(step);
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign out_valid = (state == S_DONE);
    assign sh_f      = acc;
    assign sh_h      = op;
    assign sh_d      = (state == S_RUN) ? step : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            op    <= '0;
            rem   <= '0;
            out_s <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc   <= in_f;
                        op    <= in_h;
                        rem   <= cnt_lat;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= sh_s;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        out_s <= sh_s;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_corrimiento.sv
// tb/tb_secuenciador_corrimiento.sv - randomized model-checked bench for secuenciador_corrimiento

module tb_secuenciador_corrimiento;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_f = '0;
    logic [2:0] in_h = '0;
    logic [3:0] in_cnt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_s;
    logic       busy;
    logic [3:0] sh_f;
    logic [2:0] sh_h;
    logic [1:0] sh_d;
    logic [3:0] sh_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    secuenciador_corrimiento #(.N(4), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_h(in_h), .in_cnt(in_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .busy(busy),
        .sh_f(sh_f), .sh_h(sh_h), .sh_d(sh_d), .sh_s(sh_s)
    );

    // Shift of x by n positions in one go, straight from the op definitions.
    function automatic logic [3:0] shift_ref(input logic [2:0] op, input logic [3:0] x, input int n);
        logic [3:0] r;
        int k;
        k = n % 4;
        case (op)
            3'd0:       r = x;
            3'd1, 3'd6: r = (n >= 4) ? 4'd0 : 4'(x << n);
            3'd2:       r = (n >= 4) ? 4'd0 : 4'(x >> n);
            3'd3:       r = 4'd0;
            3'd4:       r = (k == 0) ? x : 4'((x << k) | (x >> (4 - k)));
            3'd5:       r = (k == 0) ? x : 4'((x >> k) | (x << (4 - k)));
            default:    r = (n >= 4) ? {4{x[3]}} : 4'($signed(x) >>> n);
        endcase
        return r;
    endfunction

    // External combinational shift unit.
    always_comb sh_s = shift_ref(sh_h, sh_f, int'(sh_d));

    function automatic int eff_cnt(input logic [2:0] op, input logic [3:0] cnt);
        if (op == 3'd0 || op == 3'd3) return 0;
`ifdef ROT_MOD_EN
        if (op == 3'd4 || op == 3'd5) return int'(cnt) % 4;
`endif
        return int'(cnt);
    endfunction

    function automatic int run_cycles(input logic [2:0] op, input logic [3:0] cnt);
        int e;
        e = eff_cnt(op, cnt);
        return (e == 0) ? 1 : (e + 2) / 3;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running, 2 result offered.
    int         m_phase = 0;
    int         m_left = 0;
    int         m_rem = 0;
    int         m_eff = 0;
    logic [2:0] m_op = '0;
    logic [3:0] m_f = '0;
    logic [3:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_rem   <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_op    <= in_h;
                m_f     <= in_f;
                m_eff   <= eff_cnt(in_h, in_cnt);
                m_rem   <= eff_cnt(in_h, in_cnt);
                m_left  <= run_cycles(in_h, in_cnt);
                m_res   <= shift_ref(in_h, in_f, int'(in_cnt));
            end
        end else if (m_phase == 1) begin
            m_rem  <= m_rem - ((m_rem > 3) ? 3 : m_rem);
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= 2;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int done_cnt;
        chk("in_ready", int'(in_ready), int'(m_phase == 0));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("sh_d", int'(sh_d), (m_phase == 1) ? ((m_rem > 3) ? 3 : m_rem) : 0);
        if (m_phase != 0) begin
            done_cnt = m_eff - m_rem;
            chk("sh_h", int'(sh_h), int'(m_op));
            if (m_phase == 1)
                chk("sh_f", int'(sh_f), int'((done_cnt == 0) ? m_f : shift_ref(m_op, m_f, done_cnt)));
            else
                chk("sh_f", int'(sh_f), int'(m_res));
        end
        if (m_phase == 2) chk("out_s", int'(out_s), int'(m_res));
    end

    int         dseq [0:39];
    int         nruns;
    logic [3:0] got;

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_job(input logic [2:0] op, input logic [3:0] f, input logic [3:0] cnt, input int hold);
        bit seen;
        in_valid = 1'b1; in_h = op; in_f = f; in_cnt = cnt; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'($urandom); in_h = 3'($urandom); in_f = 4'($urandom); in_cnt = 4'($urandom);
        nruns = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            dseq[nruns] = int'(sh_d);
            nruns++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: out_valid never rose for op %0d cnt %0d", op, cnt);
            finish_now();
        end
        got = out_s;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_sh_f", int'(sh_f), 0);
        chk("rst_sh_h", int'(sh_h), 0);
        chk("rst_out_s", int'(out_s), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(3'b001, 4'b0001, 4'd2, 0);
        chk("shl_out", int'(got), 4'b0100);
        chk("shl_runs", nruns, 1);
        chk("shl_d0", dseq[0], 2);

        run_job(3'b101, 4'b1001, 4'd5, 1);
        chk("ror_out", int'(got), 4'b1100);
`ifdef ROT_MOD_EN
        chk("ror_runs", nruns, 1);
        chk("ror_d0", dseq[0], 1);
`else
        chk("ror_runs", nruns, 2);
        chk("ror_d0", dseq[0], 3);
        chk("ror_d1", dseq[1], 2);
`endif

        run_job(3'b111, 4'b1000, 4'd7, 5);
        chk("asr_out", int'(got), 4'b1111);
        chk("asr_runs", nruns, 3);
        chk("asr_d0", dseq[0], 3);
        chk("asr_d1", dseq[1], 3);
        chk("asr_d2", dseq[2], 1);

        run_job(3'b011, 4'b1010, 4'd9, 0);
        chk("zero_out", int'(got), 0);
        chk("zero_runs", nruns, 1);
        chk("zero_d0", dseq[0], 0);

        run_job(3'b010, 4'b0110, 4'd0, 2);
        chk("shr0_out", int'(got), 4'b0110);
        chk("shr0_runs", nruns, 1);

        run_job(3'b001, 4'b1111, 4'd15, 0);
        chk("shl15_out", int'(got), 0);
        chk("shl15_runs", nruns, 5);

        // Reset in the middle of a long arithmetic shift.
        in_valid = 1'b1; in_h = 3'b111; in_f = 4'b1000; in_cnt = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_sh_f", int'(sh_f), 0);
        chk("midrst_sh_h", int'(sh_h), 0);
        chk("midrst_sh_d", int'(sh_d), 0);
        chk("midrst_out_s", int'(out_s), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(3'b111, 4'b1000, 4'd15, 1);
        chk("postrst_out", int'(got), 4'b1111);
        chk("postrst_runs", nruns, 5);

        for (int j = 0; j < 250; j++) begin
            logic [2:0] rop;
            logic [3:0] rf;
            logic [3:0] rc;
            rop = 3'($urandom);
            rf  = 4'($urandom);
            rc  = 4'($urandom);
            run_job(rop, rf, rc, int'($urandom_range(0, 5)));
            chk("rnd_out", int'(got), int'(shift_ref(rop, rf, int'(rc))));
            chk("rnd_runs", nruns, run_cycles(rop, rc));
        end

        repeat (2) @(posedge clk);
        finish_now();
    end

endmodule
